// File: rtl/pong_frame_scheduler.sv
// Frame-end detector plus bounded vertical-blanking update window that shares one
// object-state update slot among N_REQ clients with round-robin req/gnt/done.
module pong_frame_scheduler #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int N_REQ    = 4,
  parameter int BUDGET   = 32000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9:0]       pix_x,
  input  logic [9:0]       pix_y,
  input  logic             pix_valid,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  output logic [N_REQ-1:0] gnt,
  output logic             window_open,
  output logic             frame_tick,
  output logic [15:0]      frame_count,
  output logic             overrun,
  output logic [N_REQ-1:0] missed
);
  localparam int IW = $clog2(N_REQ);

  typedef enum logic [1:0] {IDLE, ARB, GRANT, DRAIN} state_t;

  state_t           state, state_nx;
  logic [IW-1:0]    rr, rr_nx, gidx, gidx_nx, rr_inc, pick;
  logic [N_REQ-1:0] served, served_nx, gnt_nx, missed_nx, pend;
  logic [15:0]      budget, budget_nx;
  logic             overrun_nx, frame_end, close, done_g, pick_vld;

  assign frame_end   = pix_valid && (pix_x == 10'(H_ACTIVE-1)) && (pix_y == 10'(V_ACTIVE-1));
  assign window_open = (state == ARB) || (state == GRANT);
  // Budget value 1 marks the last open cycle; any visible pixel also ends the window.
  assign close       = window_open && ((budget == 16'd1) || pix_valid);
  assign done_g      = done[gidx];
  assign pend        = req & ~served;
  assign rr_inc      = (gidx == IW'(N_REQ-1)) ? '0 : gidx + 1'b1;

  // Cyclic first-pending search starting at rr; lowest offset wins.
  always_comb begin
    logic [IW-1:0] ci;
    ci       = '0;
    pick     = '0;
    pick_vld = 1'b0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      ci = IW'((int'(rr) + k) % N_REQ);
      if (pend[ci]) begin
        pick     = ci;
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    state_nx   = state;
    rr_nx      = rr;
    gidx_nx    = gidx;
    served_nx  = served;
    gnt_nx     = gnt;
    missed_nx  = missed;
    budget_nx  = budget;
    overrun_nx = 1'b0;
    case (state)
      IDLE: begin
        if (frame_end) begin
          state_nx  = ARB;
          budget_nx = 16'(BUDGET);
          served_nx = '0;
        end
      end
      ARB, GRANT: begin
        budget_nx = budget - 16'd1;
        if (state == GRANT && done_g) begin
          gnt_nx    = '0;
          served_nx = served | gnt;
          rr_nx     = rr_inc;
          state_nx  = ARB;
        end else if (state == ARB && pick_vld && !close) begin
          gnt_nx   = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
          gidx_nx  = pick;
          state_nx = GRANT;
        end
        // A done landing on the closing edge has already cleared gnt_nx above.
        if (close) begin
          budget_nx  = '0;
          missed_nx  = req & ~served_nx;
          overrun_nx = (gnt_nx != '0) || ((req & ~served_nx) != '0);
          state_nx   = (gnt_nx != '0) ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (done_g) begin
          gnt_nx   = '0;
          state_nx = IDLE;
        end
        if (frame_end) overrun_nx = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= IDLE;
      rr          <= '0;
      gidx        <= '0;
      served      <= '0;
      gnt         <= '0;
      missed      <= '0;
      budget      <= '0;
      overrun     <= 1'b0;
      frame_tick  <= 1'b0;
      frame_count <= '0;
    end else begin
      state       <= state_nx;
      rr          <= rr_nx;
      gidx        <= gidx_nx;
      served      <= served_nx;
      gnt         <= gnt_nx;
      missed      <= missed_nx;
      budget      <= budget_nx;
      overrun     <= overrun_nx;
      frame_tick  <= frame_end;
      frame_count <= frame_count + 16'(frame_end);
    end
  end
endmodule

// File: tb/tb_pong_frame_scheduler.sv
// Bench for pong_frame_scheduler: a BUDGET=100 instance for arbitration order and a
// BUDGET=8 instance for expiry/drain corner cases, sharing clock, reset and pixels.
module tb_pong_frame_scheduler;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [9:0]   pix_x = '0, pix_y = '0;
  logic         pix_valid = 1'b0;
  logic [N-1:0] req_a = '0, done_a = '0, req_b = '0, done_b = '0;
  logic [N-1:0] gnt_a, missed_a, gnt_b, missed_b;
  logic         window_open_a, frame_tick_a, overrun_a;
  logic         window_open_b, frame_tick_b, overrun_b;
  logic [15:0]  frame_count_a, frame_count_b;

  int vectors = 0;
  int errors  = 0;
  int fc      = 0;
  int exp_q[$];

  pong_frame_scheduler #(.H_ACTIVE(640), .V_ACTIVE(480), .N_REQ(N), .BUDGET(100)) dut_rr (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .req(req_a), .done(done_a), .gnt(gnt_a), .window_open(window_open_a),
    .frame_tick(frame_tick_a), .frame_count(frame_count_a), .overrun(overrun_a),
    .missed(missed_a));

  pong_frame_scheduler #(.H_ACTIVE(640), .V_ACTIVE(480), .N_REQ(N), .BUDGET(8)) dut_bx (
    .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_valid(pix_valid),
    .req(req_b), .done(done_b), .gnt(gnt_b), .window_open(window_open_b),
    .frame_tick(frame_tick_b), .frame_count(frame_count_b), .overrun(overrun_b),
    .missed(missed_b));

  always #5 clk = ~clk;

  // Grant-order scoreboard for dut_rr: each new grant pops the expected index.
  logic [N-1:0] gnt_a_prev = '0;
  always @(posedge clk) begin
    logic [N-1:0] e;
    int           idx;
    #1;
    if (rst && gnt_a != '0 && gnt_a_prev == '0) begin
      vectors++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL gnt_order: unexpected grant %b, none expected", gnt_a);
      end else begin
        idx = exp_q.pop_front();
        e   = N'(1) << idx;
        if (gnt_a !== e) begin
          errors++;
          $display("FAIL gnt_order: got %b want %b", gnt_a, e);
        end
      end
    end
    gnt_a_prev = gnt_a;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one frame-end pixel; on return the bench is in cycle T+1.
  task automatic frame_end();
    pix_valid = 1'b1; pix_x = 10'd639; pix_y = 10'd479;
    tick(1);
    pix_valid = 1'b0; pix_x = '0; pix_y = '0;
    fc++;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_a = 4'b1111; req_b = 4'b1111;
    tick(3);
    vectors++;
    if ({gnt_a, window_open_a, frame_tick_a, frame_count_a, overrun_a, missed_a} !== '0) begin
      errors++;
      $display("FAIL reset_a: gnt=%b win=%b tick=%b cnt=%0d ovr=%b missed=%b",
               gnt_a, window_open_a, frame_tick_a, frame_count_a, overrun_a, missed_a);
    end
    vectors++;
    if ({gnt_b, window_open_b, frame_tick_b, frame_count_b, overrun_b, missed_b} !== '0) begin
      errors++;
      $display("FAIL reset_b: gnt=%b win=%b tick=%b cnt=%0d ovr=%b missed=%b",
               gnt_b, window_open_b, frame_tick_b, frame_count_b, overrun_b, missed_b);
    end
    req_a = '0; req_b = '0;
    rst = 1'b1;
    tick(2);
    frame_end();
    vectors++;
    if (frame_tick_a !== 1'b1 || window_open_a !== 1'b1 || frame_count_a !== 16'd1) begin
      errors++;
      $display("FAIL first_frame: tick=%b win=%b cnt=%0d want 1 1 1",
               frame_tick_a, window_open_a, frame_count_a);
    end
    tick(1);
    vectors++;
    if (frame_tick_a !== 1'b0 || frame_tick_b !== 1'b0) begin
      errors++;
      $display("FAIL tick_pulse: tick_a=%b tick_b=%b want 0 0", frame_tick_a, frame_tick_b);
    end
    tick(98);
    vectors++;
    if (window_open_a !== 1'b1) begin
      errors++;
      $display("FAIL window_len_last: win=%b at T+100 want 1", window_open_a);
    end
    tick(1);
    vectors++;
    if (window_open_a !== 1'b0 || overrun_a !== 1'b0) begin
      errors++;
      $display("FAIL window_len_close: win=%b ovr=%b at T+101 want 0 0", window_open_a, overrun_a);
    end
    tick(5);
  endtask

  // Opens a window on dut_rr; each client answers done 3 cycles after its grant.
  task automatic serve_window_a(input logic [N-1:0] reqs, input int n_exp);
    int age, zrun, ngr;
    bit seen;
    age = -1; zrun = 0; ngr = 0; seen = 1'b0;
    req_a = reqs;
    frame_end();
    for (int c = 0; c < 40; c++) begin
      done_a = '0;
      if (gnt_a != '0) begin
        if (age < 0) begin
          ngr++;
          vectors++;
          if (zrun != 1) begin
            errors++;
            $display("FAIL rr_gap: %0d idle cycles before grant %0d want 1", zrun, ngr);
          end
          if (!seen) begin
            vectors++;
            if (c != 1) begin
              errors++;
              $display("FAIL first_grant: at T+%0d want T+2", c + 1);
            end
            seen = 1'b1;
          end
        end
        age++;
        zrun = 0;
        if (age == 3) begin
          done_a = gnt_a;
          req_a  = req_a & ~gnt_a;
        end
      end else begin
        age = -1;
        zrun++;
      end
      tick(1);
    end
    done_a = '0;
    vectors++;
    if (ngr != n_exp) begin
      errors++;
      $display("FAIL rr_count: %0d grants want %0d", ngr, n_exp);
    end
    tick(60);
    vectors++;
    if (window_open_a !== 1'b0 || missed_a !== '0 || overrun_a !== 1'b0) begin
      errors++;
      $display("FAIL rr_close: win=%b missed=%b ovr=%b want 0 0000 0",
               window_open_a, missed_a, overrun_a);
    end
    tick(5);
  endtask

  task automatic test_round_robin();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    serve_window_a(4'b1111, 4);
  endtask

  task automatic test_fairness();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    serve_window_a(4'b1111, 4);
    exp_q.push_back(1); exp_q.push_back(3);
    serve_window_a(4'b1010, 2);
  endtask

  task automatic test_budget_expiry();
    req_b = 4'b0100;
    frame_end();
    tick(1);
    vectors++;
    if (gnt_b !== 4'b0100) begin
      errors++;
      $display("FAIL bx_grant: gnt=%b want 0100", gnt_b);
    end
    tick(6);
    vectors++;
    if (window_open_b !== 1'b1 || overrun_b !== 1'b0) begin
      errors++;
      $display("FAIL bx_last_open: win=%b ovr=%b at T+8 want 1 0", window_open_b, overrun_b);
    end
    tick(1);
    vectors++;
    if (window_open_b !== 1'b0 || overrun_b !== 1'b1 || gnt_b !== 4'b0100 || missed_b !== 4'b0100) begin
      errors++;
      $display("FAIL bx_expire: win=%b ovr=%b gnt=%b missed=%b want 0 1 0100 0100",
               window_open_b, overrun_b, gnt_b, missed_b);
    end
    tick(1);
    vectors++;
    if (overrun_b !== 1'b0 || gnt_b !== 4'b0100) begin
      errors++;
      $display("FAIL bx_drain_hold: ovr=%b gnt=%b want 0 0100", overrun_b, gnt_b);
    end
    tick(10);
    done_b = 4'b0100; req_b = '0;
    tick(1);
    done_b = '0;
    vectors++;
    if (gnt_b !== '0 || overrun_b !== 1'b0) begin
      errors++;
      $display("FAIL bx_release: gnt=%b ovr=%b at T+21 want 0000 0", gnt_b, overrun_b);
    end
    tick(90);
  endtask

  task automatic test_skipped_frame();
    req_b = 4'b0100;
    frame_end();
    tick(8);
    vectors++;
    if (gnt_b !== 4'b0100 || window_open_b !== 1'b0) begin
      errors++;
      $display("FAIL skip_drain: gnt=%b win=%b want 0100 0", gnt_b, window_open_b);
    end
    tick(100);
    frame_end();
    vectors++;
    if (frame_tick_b !== 1'b1 || frame_count_b !== 16'(fc) || window_open_b !== 1'b0 ||
        overrun_b !== 1'b1 || gnt_b !== 4'b0100) begin
      errors++;
      $display("FAIL skip_frame: tick=%b cnt=%0d win=%b ovr=%b gnt=%b want 1 %0d 0 1 0100",
               frame_tick_b, frame_count_b, window_open_b, overrun_b, gnt_b, fc);
    end
    done_b = 4'b0100; req_b = '0;
    tick(1);
    done_b = '0;
    vectors++;
    if (gnt_b !== '0 || overrun_b !== 1'b0) begin
      errors++;
      $display("FAIL skip_release: gnt=%b ovr=%b want 0000 0", gnt_b, overrun_b);
    end
    tick(105);
  endtask

  task automatic test_early_close();
    req_a = 4'b1100;
    exp_q.push_back(2);
    frame_end();
    tick(4);
    pix_valid = 1'b1;
    tick(1);
    pix_valid = 1'b0;
    vectors++;
    if (window_open_a !== 1'b0 || missed_a !== 4'b1100 || overrun_a !== 1'b1 || gnt_a !== 4'b0100) begin
      errors++;
      $display("FAIL early_close: win=%b missed=%b ovr=%b gnt=%b want 0 1100 1 0100",
               window_open_a, missed_a, overrun_a, gnt_a);
    end
    done_a = 4'b0100; req_a = '0;
    tick(1);
    done_a = '0;
    vectors++;
    if (gnt_a !== '0 || overrun_a !== 1'b0) begin
      errors++;
      $display("FAIL early_release: gnt=%b ovr=%b want 0000 0", gnt_a, overrun_a);
    end
    tick(20);
  endtask

  task automatic test_simultaneous();
    req_b = 4'b0001;
    frame_end();
    tick(1);
    vectors++;
    if (gnt_b !== 4'b0001) begin
      errors++;
      $display("FAIL sim1_grant: gnt=%b want 0001", gnt_b);
    end
    tick(6);
    done_b = 4'b0001; req_b = '0;
    tick(1);
    done_b = '0;
    vectors++;
    if (window_open_b !== 1'b0 || gnt_b !== '0 || overrun_b !== 1'b0 || missed_b !== '0) begin
      errors++;
      $display("FAIL sim1_close: win=%b gnt=%b ovr=%b missed=%b want 0 0000 0 0000",
               window_open_b, gnt_b, overrun_b, missed_b);
    end
    tick(100);
    // rr now points past client 0, so client 1 goes first and client 0 is left pending.
    req_b = 4'b0011;
    frame_end();
    tick(1);
    vectors++;
    if (gnt_b !== 4'b0010) begin
      errors++;
      $display("FAIL sim2_grant: gnt=%b want 0010", gnt_b);
    end
    tick(6);
    done_b = 4'b0010; req_b = 4'b0001;
    tick(1);
    done_b = '0;
    vectors++;
    if (window_open_b !== 1'b0 || gnt_b !== '0 || overrun_b !== 1'b1 || missed_b !== 4'b0001) begin
      errors++;
      $display("FAIL sim2_close: win=%b gnt=%b ovr=%b missed=%b want 0 0000 1 0001",
               window_open_b, gnt_b, overrun_b, missed_b);
    end
    req_b = '0;
    tick(100);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_fairness();
    test_budget_expiry();
    test_skipped_frame();
    test_early_close();
    test_simultaneous();
    vectors++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL gnt_order_left: %0d expected grants never seen want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
